// File: rtl/ctr_obs_queue_cmp.sv
// ctr_obs_queue_cmp
//   Contract-equivalence checker for two independent executions. Each
//   execution pushes one observation vector per retirement into its own
//   FIFO, so the two sides need not retire in lock-step. Whenever both
//   FIFOs hold an entry, the heads are popped together and compared under
//   OBS_MASK. Once both executions report done, the remaining pairs drain.
//   If one FIFO still holds entries after the other runs dry, the runs
//   retired a different number of instructions and the verdict is cleared.
//
// Optional feature: define CTR_CMP_DIFF_EN to add fail_diff_o, which holds
//   the masked difference vector of the first mismatching pair.
//
// Ports
//   clk_i, rst_ni            clock (posedge), asynchronous active-low reset
//   retire_1_i, obs_1_i      execution 1 retirement strobe and observation
//   retire_2_i, obs_2_i      execution 2 retirement strobe and observation
//   done_1_i, done_2_i       execution finished (pulse or level, held sticky)
//   equiv_o                  sticky verdict, 1 while nothing has gone wrong
//   overflow_o               sticky, a push was dropped on a full FIFO
//   done_o                   final verdict valid
//   cmp_cnt_o                pairs compared, saturating
//   fail_idx_o               cmp_cnt_o value at the first mismatch
//   fail_seen_o              sticky, a masked mismatch has occurred
//   fail_diff_o              (CTR_CMP_DIFF_EN) masked diff of first mismatch
module ctr_obs_queue_cmp #(
  parameter int XLEN = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int OBS_W = 35 + 7 * XLEN,
  parameter logic [OBS_W-1:0] OBS_MASK = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             retire_1_i,
  input  logic [OBS_W-1:0] obs_1_i,
  input  logic             retire_2_i,
  input  logic [OBS_W-1:0] obs_2_i,
  input  logic             done_1_i,
  input  logic             done_2_i,
  output logic             equiv_o,
  output logic             overflow_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cmp_cnt_o,
  output logic [CNT_W-1:0] fail_idx_o,
  output logic             fail_seen_o
`ifdef CTR_CMP_DIFF_EN
  ,
  output logic [OBS_W-1:0] fail_diff_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [OBS_W-1:0] mem1 [DEPTH];
  logic [OBS_W-1:0] mem2 [DEPTH];
  logic [AW:0]      wp1, rp1, wp2, rp2;
  logic             done1_q, done2_q;

  logic             empty1, empty2, full1, full2;
  logic             active;
  logic             push1, push2, drop1, drop2;
  logic             len_err;
  logic [OBS_W-1:0] head1_p0, head2_p0, diff_p0;
  logic             vld_p0, mism_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: FIFO heads, pair pop and masked compare, all resolved this edge
  always_comb begin
    empty1   = (wp1 == rp1);
    empty2   = (wp2 == rp2);
    full1    = (wp1 == {~rp1[AW], rp1[AW-1:0]});
    full2    = (wp2 == {~rp2[AW], rp2[AW-1:0]});
    active   = (state != DONE);
    head1_p0 = mem1[rp1[AW-1:0]];
    head2_p0 = mem2[rp2[AW-1:0]];
    vld_p0   = !empty1 && !empty2 && active;
    diff_p0  = (head1_p0 ^ head2_p0) & OBS_MASK;
    mism_p0  = vld_p0 && (|diff_p0);
    // A full FIFO still takes a push when its head leaves on the same edge.
    push1    = retire_1_i && active && (!full1 || vld_p0);
    push2    = retire_2_i && active && (!full2 || vld_p0);
    drop1    = retire_1_i && active && full1 && !vld_p0;
    drop2    = retire_2_i && active && full2 && !vld_p0;
    len_err  = (state == DRAIN) && !vld_p0 && (empty1 != empty2);
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (done1_q && done2_q) state_nx = DRAIN;
      DRAIN:   if ((empty1 || empty2) && !vld_p0) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= RUN;
    else         state <= state_nx;
  end

  always_ff @(posedge clk_i) begin
    if (push1) mem1[wp1[AW-1:0]] <= obs_1_i;
    if (push2) mem2[wp2[AW-1:0]] <= obs_2_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp1         <= '0;
      rp1         <= '0;
      wp2         <= '0;
      rp2         <= '0;
      done1_q     <= 1'b0;
      done2_q     <= 1'b0;
      equiv_o     <= 1'b1;
      overflow_o  <= 1'b0;
      cmp_cnt_o   <= '0;
      fail_idx_o  <= '0;
      fail_seen_o <= 1'b0;
    end else begin
      if (push1) wp1 <= wp1 + PTR_ONE;
      if (push2) wp2 <= wp2 + PTR_ONE;
      if (vld_p0) begin
        rp1       <= rp1 + PTR_ONE;
        rp2       <= rp2 + PTR_ONE;
        cmp_cnt_o <= sat_inc(cmp_cnt_o);
      end
      if (done_1_i) done1_q <= 1'b1;
      if (done_2_i) done2_q <= 1'b1;
      if (drop1 || drop2) overflow_o <= 1'b1;
      if (drop1 || drop2 || mism_p0 || len_err) equiv_o <= 1'b0;
      if (mism_p0 && !fail_seen_o) begin
        fail_seen_o <= 1'b1;
        fail_idx_o  <= cmp_cnt_o;
      end
    end
  end

`ifdef CTR_CMP_DIFF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     fail_diff_o <= '0;
    else if (mism_p0 && !fail_seen_o) fail_diff_o <= diff_p0;
  end
`endif

  assign done_o = (state == DONE);

endmodule
